// File: rtl/trap_sequencer.sv
// Trap/xRET sequencer: captures a committing exception or xRET, writes the
// trap CSRs one per cycle, then redirects fetch and updates privilege.
// Latency: trap 5 cycles capture-to-redirect (+1 per mem_busy drain cycle), xRET 2 cycles.
// Backpressure: mem_busy holds the sequence in DRAIN before any CSR write; events while busy are dropped.
module trap_sequencer #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            except_valid,
  input  logic [XLEN-1:0] except_epc,
  input  logic [XLEN-1:0] except_cause,
  input  logic [XLEN-1:0] except_tval,
  input  logic            mret_valid,
  input  logic            sret_valid,
  input  logic [1:0]      priv,
  input  logic [XLEN-1:0] medeleg,
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] stvec,
  input  logic [XLEN-1:0] mepc,
  input  logic [XLEN-1:0] sepc,
  input  logic [XLEN-1:0] mstatus,
  input  logic            mem_busy,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            flush,
  output logic            stall_front,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            priv_we,
  output logic [1:0]      priv_next,
  output logic            busy
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DRAIN    = 3'd1;
  localparam logic [2:0] W_EPC    = 3'd2;
  localparam logic [2:0] W_CAUSE  = 3'd3;
  localparam logic [2:0] W_TVAL   = 3'd4;
  localparam logic [2:0] W_STATUS = 3'd5;
  localparam logic [2:0] REDIRECT = 3'd6;

  logic [2:0]      state, state_nxt;
  logic            is_trap_q;   // 1: exception path, 0: xRET path
  logic            tgt_m_q;     // trap target M / mret (1), trap target S / sret (0)
  logic [XLEN-1:0] epc_q, cause_q, tval_q, mstatus_q, tvec_q, xepc_q;
  logic [1:0]      priv_q;
  logic            deleg_s;
  logic            capture;
  logic [XLEN-1:0] status_nxt;
  logic [XLEN-1:0] tvec_base;
  logic [XLEN-1:0] trap_pc;
  logic            unused_bits;

  assign deleg_s = (priv != 2'd3) && medeleg[except_cause[5:0]] && !except_cause[XLEN-1];
  assign capture = (state == IDLE) && (except_valid || mret_valid || sret_valid);

  // State register; reset drops any in-flight sequence straight to IDLE
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state: exception beats mret beats sret; nothing is sampled outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (except_valid)                  state_nxt = mem_busy ? DRAIN : W_EPC;
        else if (mret_valid || sret_valid) state_nxt = W_STATUS;
      end
      DRAIN:    state_nxt = mem_busy ? DRAIN : W_EPC;
      W_EPC:    state_nxt = W_CAUSE;
      W_CAUSE:  state_nxt = W_TVAL;
      W_TVAL:   state_nxt = W_STATUS;
      W_STATUS: state_nxt = REDIRECT;
      REDIRECT: state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Operand capture on the winning event; held for the whole sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_trap_q <= 1'b0;
      tgt_m_q   <= 1'b0;
      epc_q     <= '0;
      cause_q   <= '0;
      tval_q    <= '0;
      mstatus_q <= '0;
      tvec_q    <= '0;
      xepc_q    <= '0;
      priv_q    <= 2'd0;
    end else if (capture) begin
      is_trap_q <= except_valid;
      tgt_m_q   <= except_valid ? !deleg_s : mret_valid;
      epc_q     <= except_epc;
      cause_q   <= except_cause;
      tval_q    <= except_tval;
      mstatus_q <= mstatus;
      tvec_q    <= deleg_s ? stvec : mtvec;
      xepc_q    <= mret_valid ? mepc : sepc;
      priv_q    <= priv;
    end
  end

  // Updated mstatus image for trap entry or xRET, at the selected level
  always_comb begin
    status_nxt = mstatus_q;
    if (is_trap_q) begin
      if (tgt_m_q) begin
        status_nxt[7]     = mstatus_q[3];
        status_nxt[3]     = 1'b0;
        status_nxt[12:11] = priv_q;
      end else begin
        status_nxt[5] = mstatus_q[1];
        status_nxt[1] = 1'b0;
        status_nxt[8] = priv_q[0];
      end
    end else if (tgt_m_q) begin
      status_nxt[3]     = mstatus_q[7];
      status_nxt[7]     = 1'b1;
      status_nxt[12:11] = 2'b00;
    end else begin
      status_nxt[1] = mstatus_q[5];
      status_nxt[5] = 1'b1;
      status_nxt[8] = 1'b0;
    end
  end

  // Vectored mode only offsets interrupts; exceptions always land on the base
  assign tvec_base = {tvec_q[XLEN-1:2], 2'b00};
  assign trap_pc   = (tvec_q[1:0] == 2'b01 && cause_q[XLEN-1])
                   ? tvec_base + {{(XLEN-8){1'b0}}, cause_q[5:0], 2'b00}
                   : tvec_base;

  // Moore outputs: all zero in IDLE, which also covers the reset-held case
  always_comb begin
    csr_we         = 1'b0;
    csr_waddr      = 12'h000;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    priv_we        = 1'b0;
    priv_next      = 2'd0;
    case (state)
      W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = tgt_m_q ? 12'h341 : 12'h141;
        csr_wdata = epc_q;
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = tgt_m_q ? 12'h342 : 12'h142;
        csr_wdata = cause_q;
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = tgt_m_q ? 12'h343 : 12'h143;
        csr_wdata = tval_q;
      end
      W_STATUS: begin
        csr_we    = 1'b1;
        csr_waddr = tgt_m_q ? 12'h300 : 12'h100;
        csr_wdata = status_nxt;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        priv_we        = 1'b1;
        if (is_trap_q) begin
          redirect_pc = trap_pc;
          priv_next   = tgt_m_q ? 2'd3 : 2'd1;
        end else begin
          redirect_pc = {xepc_q[XLEN-1:1], 1'b0};
          priv_next   = tgt_m_q ? mstatus_q[12:11] : {1'b0, mstatus_q[8]};
        end
      end
      default: ;
    endcase
  end

  assign busy        = (state != IDLE);
  assign flush       = busy;
  assign stall_front = busy;

  // xRET targets are halfword-aligned, so the low epc bit is dropped
  assign unused_bits = xepc_q[0];

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer with a CSR-write / redirect scoreboard.
// Latency: expected cycle of every write and redirect is checked.
// Backpressure: mem_busy drain, busy-time event drops and mid-sequence reset are exercised.
module tb_trap_sequencer;

  typedef struct {
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } csr_exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [1:0]  pv;
    int          cyc;
  } rd_exp_t;

  logic        clk;
  logic        rst;
  logic        except_valid;
  logic [63:0] except_epc, except_cause, except_tval;
  logic        mret_valid, sret_valid;
  logic [1:0]  priv;
  logic [63:0] medeleg, mtvec, stvec, mepc, sepc, mstatus;
  logic        mem_busy;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata;
  logic        flush, stall_front, redirect_valid, priv_we, busy;
  logic [63:0] redirect_pc;
  logic [1:0]  priv_next;

  csr_exp_t cq[$];
  rd_exp_t  rq[$];
  int       cyc = 0;
  int       n_cmp = 0;
  int       n_err = 0;

  trap_sequencer #(.XLEN(64)) dut (
    .clk(clk), .rst(rst),
    .except_valid(except_valid), .except_epc(except_epc),
    .except_cause(except_cause), .except_tval(except_tval),
    .mret_valid(mret_valid), .sret_valid(sret_valid), .priv(priv),
    .medeleg(medeleg), .mtvec(mtvec), .stvec(stvec), .mepc(mepc),
    .sepc(sepc), .mstatus(mstatus), .mem_busy(mem_busy),
    .csr_we(csr_we), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .flush(flush), .stall_front(stall_front),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .priv_we(priv_we), .priv_next(priv_next), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: pop and compare whenever the DUT writes a CSR or redirects
  always @(negedge clk) begin
    csr_exp_t ce;
    rd_exp_t  re;
    if (csr_we === 1'b1) begin
      if (cq.size() == 0) chk("unexpected_csr_we", {52'd0, csr_waddr}, 64'd0);
      else begin
        ce = cq.pop_front();
        chk("csr_waddr", {52'd0, csr_waddr}, {52'd0, ce.addr});
        chk("csr_wdata", csr_wdata, ce.data);
        chk("csr_cycle", 64'(cyc), 64'(ce.cyc));
        chk("csr_no_redirect", {63'd0, redirect_valid}, 64'd0);
      end
    end
    if (redirect_valid === 1'b1) begin
      if (rq.size() == 0) chk("unexpected_redirect", redirect_pc, 64'd0);
      else begin
        re = rq.pop_front();
        chk("redirect_pc", redirect_pc, re.pc);
        chk("priv_next", {62'd0, priv_next}, {62'd0, re.pv});
        chk("priv_we", {63'd0, priv_we}, 64'd1);
        chk("redirect_cycle", 64'(cyc), 64'(re.cyc));
      end
    end
  end

  task automatic clear_inputs();
    except_valid = 0; mret_valid = 0; sret_valid = 0; mem_busy = 0;
    except_epc = 0; except_cause = 0; except_tval = 0; priv = 0;
    medeleg = 0; mtvec = 0; stvec = 0; mepc = 0; sepc = 0; mstatus = 0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((rq.size() != 0 || cq.size() != 0) && k < 40) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk); #1;
    chk({tag, "_pending"}, 64'(rq.size() + cq.size()), 64'd0);
    chk({tag, "_idle"}, {63'd0, busy}, 64'd0);
  endtask

  // Exception: d = number of capture-aligned cycles mem_busy is held high
  task automatic do_trap(input string tag, input logic [1:0] p,
                         input logic [63:0] cause, input logic [63:0] epc,
                         input logic [63:0] tval, input logic [63:0] deleg,
                         input logic [63:0] mtv, input logic [63:0] stv,
                         input logic [63:0] ms, input int d, input logic poke,
                         input logic exp_s, input logic [63:0] exp_ms,
                         input logic [63:0] exp_pc);
    int cap;
    logic [11:0] b;
    @(negedge clk);
    except_valid = 1; except_cause = cause; except_epc = epc; except_tval = tval;
    priv = p; medeleg = deleg; mtvec = mtv; stvec = stv; mstatus = ms;
    mem_busy = (d > 0);
    cap = cyc;
    b = exp_s ? 12'h140 : 12'h340;
    cq.push_back('{b + 12'd1, epc,   cap + 1 + d});
    cq.push_back('{b + 12'd2, cause, cap + 2 + d});
    cq.push_back('{b + 12'd3, tval,  cap + 3 + d});
    cq.push_back('{exp_s ? 12'h100 : 12'h300, exp_ms, cap + 4 + d});
    rq.push_back('{exp_pc, exp_s ? 2'd1 : 2'd3, cap + 5 + d});
    @(posedge clk); #1;
    except_valid = 0;
    chk({tag, "_busy"}, {61'd0, busy, flush, stall_front}, 64'h7);
    if (d > 0) begin
      chk({tag, "_drain_we"}, {63'd0, csr_we}, 64'd0);
      for (int k = 1; k < d; k++) begin
        @(posedge clk); #1;
        chk({tag, "_drain_we"}, {63'd0, csr_we}, 64'd0);
      end
      mem_busy = 0;
    end
    if (poke) begin
      @(negedge clk);
      except_valid = 1; sret_valid = 1; except_cause = 64'd5;
      except_epc = 64'hdead; mtvec = 0; mstatus = 64'hffff;
      @(negedge clk);
      except_valid = 0; sret_valid = 0;
    end
    wait_done(tag);
  endtask

  task automatic do_ret(input string tag, input logic is_m, input logic both,
                        input logic [1:0] p, input logic [63:0] me,
                        input logic [63:0] se, input logic [63:0] ms,
                        input logic [63:0] exp_ms, input logic [63:0] exp_pc,
                        input logic [1:0] exp_pv);
    int cap;
    @(negedge clk);
    mret_valid = is_m; sret_valid = !is_m || both;
    priv = p; mepc = me; sepc = se; mstatus = ms;
    cap = cyc;
    cq.push_back('{is_m ? 12'h300 : 12'h100, exp_ms, cap + 1});
    rq.push_back('{exp_pc, exp_pv, cap + 2});
    @(posedge clk); #1;
    mret_valid = 0; sret_valid = 0;
    chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
    wait_done(tag);
  endtask

  initial begin
    int cap;
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int cap;
    clear_inputs();
    rst = 0;
    #23;
    chk("rst_outputs", {busy, flush, stall_front, csr_we, redirect_valid, priv_we},  64'd0);
    chk("rst_pc_priv", redirect_pc | {62'd0, priv_next}, 64'd0);
    @(negedge clk); rst = 1;

    // M-mode trap from U, no delegation
    do_trap("m_trap", 2'd0, 64'd2, 64'h8000_0010, 64'h1234, 64'd0,
            64'h8000_1000, 64'h0, 64'hA, 0, 1, 0, 64'h82, 64'h8000_1000);
    // Delegated to S from U
    do_trap("s_trap", 2'd0, 64'd2, 64'h8000_0010, 64'h55, 64'h4,
            64'h8000_1000, 64'h8000_2000, 64'hA, 0, 0, 1, 64'h28, 64'h8000_2000);
    // Delegated to S from S: SPP records 1
    do_trap("s_from_s", 2'd1, 64'd2, 64'h8000_0020, 64'h0, 64'h4,
            64'h8000_1000, 64'h8000_2000, 64'h0, 0, 0, 1, 64'h100, 64'h8000_2000);
    // Delegation ignored from M: MPP records 3
    do_trap("m_from_m", 2'd3, 64'd2, 64'h8000_0030, 64'h7, 64'h4,
            64'h8000_3000, 64'h8000_2000, 64'h0, 0, 0, 0, 64'h1800, 64'h8000_3000);
    // Three drain cycles; vectored mtvec but exception lands on base
    do_trap("drain", 2'd0, 64'd2, 64'h8000_0010, 64'h99, 64'd0,
            64'h8000_1001, 64'h0, 64'h8, 3, 0, 0, 64'h80, 64'h8000_1000);
    // mret with sret also asserted: mret wins
    do_ret("mret", 1, 1, 2'd3, 64'h8000_0041, 64'h8000_0101, 64'h880,
           64'h88, 64'h8000_0040, 2'd1);
    // sret back to U
    do_ret("sret", 0, 0, 2'd1, 64'h8000_0041, 64'h8000_0101, 64'h20,
           64'h22, 64'h8000_0100, 2'd0);

    // Exception and mret together, then reset during W_CAUSE
    @(negedge clk);
    clear_inputs();
    except_valid = 1; mret_valid = 1; except_cause = 64'd2;
    except_epc = 64'h8000_0010; mtvec = 64'h8000_1000; mepc = 64'h8000_0700;
    mstatus = 64'h880; priv = 2'd0;
    cap = cyc;
    cq.push_back('{12'h341, 64'h8000_0010, cap + 1});
    @(posedge clk); #1;
    except_valid = 0; mret_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    #1;
    chk("rst_mid_ctl", {busy, flush, stall_front, csr_we, redirect_valid, priv_we}, 64'd0);
    chk("rst_mid_data", redirect_pc | csr_wdata | {52'd0, csr_waddr} | {62'd0, priv_next}, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1;
    chk("rst_mid_pending", 64'(cq.size() + rq.size()), 64'd0);

    // Vectored interrupt right after release: captured on the first edge
    do_trap("irq_vec", 2'd0, 64'h8000_0000_0000_0007, 64'h8000_0050, 64'h0,
            64'hffff_ffff_ffff_ffff, 64'h8000_1001, 64'h8000_2000, 64'h8, 0, 0, 0,
            64'h80, 64'h8000_101C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
